// File: rtl/obj_table_if.sv
// obj_table_if: command/status bundle between an object-table client and obj_table.
// master modport: client side (drives commands and frame_start, observes the table).
// slave modport: obj_table side (accepts commands, presents packed table, length, status).
interface obj_table_if #(
  parameter int OBJ_WIDTH = 66,
  parameter int MAX_LEN   = 16,
  parameter int LEN_BITS  = 6
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [1:0]                   cmd_op;
  logic [LEN_BITS-1:0]          cmd_idx;
  logic [OBJ_WIDTH-1:0]         cmd_obj;
  logic                         frame_start;
  logic [OBJ_WIDTH*MAX_LEN-1:0] obj_arr_packed;
  logic [LEN_BITS-1:0]          arr_len;
  logic                         busy;
  logic                         err;

  modport master (
    output cmd_valid, cmd_op, cmd_idx, cmd_obj, frame_start,
    input  cmd_ready, obj_arr_packed, arr_len, busy, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, cmd_obj, frame_start,
    output cmd_ready, obj_arr_packed, arr_len, busy, err
  );
endinterface

// File: rtl/obj_table.sv
// obj_table: handshaked object table (ADD/UPDATE/DELETE with compaction/CLEAR) feeding the renderer.
// Ports: clk, rst (async active-high), bus_if (obj_table_if.slave: cmd_* in, table/len/busy/err out).
// Latency 1 for ADD/UPDATE; DELETE at k busy len-k cycles; CLEAR busy MAX_LEN cycles; cmd_ready = !busy.
// Optional macro OBJ_DBUF_EN: outputs come from a live copy committed from the working table on frame_start.
module obj_table #(
  parameter int OBJ_WIDTH = 66,
  parameter int MAX_LEN   = 16,
  parameter int LEN_BITS  = 6
) (
  input logic         clk,
  input logic         rst,
  obj_table_if.slave  bus_if
);
  localparam int IDX_BITS = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_BITS-1:0] MAX_L  = LEN_BITS'(MAX_LEN);
  localparam logic [LEN_BITS-1:0] LAST_L = LEN_BITS'(MAX_LEN - 1);

  typedef logic [IDX_BITS-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, SHIFT, WIPE} state_t;

  localparam logic [1:0] OP_ADD = 2'd0, OP_UPD = 2'd1, OP_DEL = 2'd2, OP_CLR = 2'd3;

  state_t               state_q, state_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [LEN_BITS-1:0]  p_q, p_d;
  logic                 err_q, err_d;
  logic [OBJ_WIDTH-1:0] slots_q [MAX_LEN];

  // Single write port into the working table, chosen by the FSM each cycle.
  logic                 wr_en;
  idx_t                 wr_idx;
  logic [OBJ_WIDTH-1:0] wr_dat;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    p_d     = p_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_dat  = '0;
    case (state_q)
      IDLE: begin
        if (bus_if.cmd_valid) begin
          case (bus_if.cmd_op)
            OP_ADD: begin
              if (len_q < MAX_L) begin
                wr_en  = 1'b1;
                wr_idx = idx_t'(len_q);
                wr_dat = bus_if.cmd_obj;
                len_d  = len_q + 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_UPD: begin
              // len_q <= MAX_LEN, so an in-range idx always fits idx_t.
              if (bus_if.cmd_idx < len_q) begin
                wr_en  = 1'b1;
                wr_idx = idx_t'(bus_if.cmd_idx);
                wr_dat = bus_if.cmd_obj;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_DEL: begin
              if (bus_if.cmd_idx < len_q) begin
                p_d     = bus_if.cmd_idx;
                state_d = SHIFT;
              end else begin
                err_d = 1'b1;
              end
            end
            default: begin // OP_CLR
              len_d   = '0;
              p_d     = '0;
              state_d = WIPE;
            end
          endcase
        end
      end
      SHIFT: begin
        // Compaction walks up from the deleted slot; the last valid slot is zeroed.
        wr_en  = 1'b1;
        wr_idx = idx_t'(p_q);
        if (p_q < len_q - 1'b1) begin
          wr_dat = slots_q[idx_t'(p_q + 1'b1)];
          p_d    = p_q + 1'b1;
        end else begin
          wr_dat  = '0;
          len_d   = len_q - 1'b1;
          state_d = IDLE;
        end
      end
      WIPE: begin
        wr_en  = 1'b1;
        wr_idx = idx_t'(p_q);
        wr_dat = '0;
        p_d    = p_q + 1'b1;
        if (p_q == LAST_L) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) slots_q[i] <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      p_q     <= p_d;
      err_q   <= err_d;
      if (wr_en) slots_q[wr_idx] <= wr_dat;
    end
  end

  logic                 idle;
  logic [OBJ_WIDTH-1:0] out_slots [MAX_LEN];
  logic [LEN_BITS-1:0]  out_len;

  assign idle = (state_q == IDLE);

`ifdef OBJ_DBUF_EN
  // Live copy seen by the renderer; committed whole from the working table
  // on the first IDLE edge at or after a frame_start pulse.
  logic [OBJ_WIDTH-1:0] live_slots_q [MAX_LEN];
  logic [LEN_BITS-1:0]  live_len_q;
  logic                 pend_q, pend_d;
  logic                 copy_en;

  always_comb begin
    copy_en = idle && (bus_if.frame_start || pend_q);
    pend_d  = pend_q;
    if (copy_en)                 pend_d = 1'b0;
    else if (bus_if.frame_start) pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= 1'b0;
      live_len_q <= '0;
      for (int i = 0; i < MAX_LEN; i++) live_slots_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      if (copy_en) begin
        live_len_q <= len_q;
        for (int i = 0; i < MAX_LEN; i++) live_slots_q[i] <= slots_q[i];
      end
    end
  end

  assign out_slots = live_slots_q;
  assign out_len   = live_len_q;
`else
  logic unused_frame_start;
  assign unused_frame_start = bus_if.frame_start;
  assign out_slots = slots_q;
  assign out_len   = len_q;
`endif

  // Slots at or beyond the length read as zero even while WIPE is still
  // clearing the storage behind an already-zeroed length.
  always_comb begin
    bus_if.obj_arr_packed = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_BITS'(i) < out_len)
        bus_if.obj_arr_packed[i*OBJ_WIDTH +: OBJ_WIDTH] = out_slots[i];
    end
  end

  assign bus_if.arr_len   = out_len;
  assign bus_if.busy      = !idle;
  assign bus_if.cmd_ready = idle;
  assign bus_if.err       = err_q;
endmodule

// File: tb/tb_obj_table.sv
// tb_obj_table: directed self-checking bench for obj_table.
// Drives commands #1 after posedge, samples #1 after posedge.
module tb_obj_table;
  localparam int W = 66;
  localparam int N = 16;
  localparam int L = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  obj_table_if #(.OBJ_WIDTH(W), .MAX_LEN(N), .LEN_BITS(L)) bus ();

  obj_table #(.OBJ_WIDTH(W), .MAX_LEN(N), .LEN_BITS(L)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus.slave)
  );

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] slot(input int i);
    return bus.obj_arr_packed[i*W +: W];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.frame_start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Present one command for exactly one (accepting) edge; returns #1 after it.
  task automatic send(input logic [1:0] op, input logic [L-1:0] idx, input logic [W-1:0] obj);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_idx   = idx;
    bus.cmd_obj   = obj;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic add_n(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) send(2'd0, '0, base + W'(i));
  endtask

  // Count cycles with busy high, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  int n;

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = '0;
    bus.cmd_idx     = '0;
    bus.cmd_obj     = '0;
    bus.frame_start = 1'b0;
    #2;
    // Reset state while reset is asserted.
    check("rst_ready", W'(bus.cmd_ready), 1);
    check("rst_busy",  W'(bus.busy), 0);
    check("rst_err",   W'(bus.err), 0);
    check("rst_len",   W'(bus.arr_len), 0);
    check("rst_arr",   W'(|bus.obj_arr_packed), 0);
    do_reset();

`ifdef OBJ_DBUF_EN
    // Working table changes stay hidden until committed.
    send(2'd0, '0, W'(12'h0f0));
    check("db_hidden_len", W'(bus.arr_len), 0);
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    check("db_commit_len", W'(bus.arr_len), 1);
    check("db_commit_s0",  slot(0), W'(12'h0f0));
    send(2'd0, '0, W'(12'hfff));
    send(2'd0, '0, W'(12'hf00));
    send(2'd2, 6'd0, '0);        // shadow len 3 -> busy 3 cycles
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    n = 1;
    while (bus.busy && n < 100) begin
      check("db_hold_len", W'(bus.arr_len), 1);
      n++;
      @(posedge clk); #1;
    end
    check("db_busy_cycles", W'(n), 3);
    check("db_idle_len",  W'(bus.arr_len), 1);
    check("db_idle_s0",   slot(0), W'(12'h0f0));
    @(posedge clk); #1;
    check("db_late_len",  W'(bus.arr_len), 2);
    check("db_late_s0",   slot(0), W'(12'hfff));
    check("db_late_s1",   slot(1), W'(12'hf00));
    check("db_late_s2",   slot(2), 0);
`else
    // Three back-to-back ADDs, ready never drops.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd0;
    bus.cmd_obj   = W'(12'h0f0);
    @(posedge clk); #1;
    check("add1_ready", W'(bus.cmd_ready), 1);
    check("add1_len",   W'(bus.arr_len), 1);
    bus.cmd_obj = W'(12'hfff);
    @(posedge clk); #1;
    check("add2_ready", W'(bus.cmd_ready), 1);
    bus.cmd_obj = W'(12'hf00);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("add3_ready", W'(bus.cmd_ready), 1);
    check("add3_len",   W'(bus.arr_len), 3);
    check("add_s0",     slot(0), W'(12'h0f0));
    check("add_s1",     slot(1), W'(12'hfff));
    check("add_s2",     slot(2), W'(12'hf00));
    check("add_s3",     slot(3), 0);

    // UPDATE slot 1, then out-of-range UPDATE.
    send(2'd1, 6'd1, W'(66'h2_0000_0000_0000_0abc));
    check("upd_s1",  slot(1), W'(66'h2_0000_0000_0000_0abc));
    check("upd_err0", W'(bus.err), 0);
    send(2'd1, 6'd3, W'(12'h123));
    check("upd_oob_err", W'(bus.err), 1);
    check("upd_oob_s3",  slot(3), 0);

    // frame_start has no effect in this build.
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    check("fs_len", W'(bus.arr_len), 3);

    // Fill to 16, then overflow.
    add_n(13, W'(12'h100));
    check("full_len", W'(bus.arr_len), 16);
    check("full_s15", slot(15), W'(12'h10c));
    send(2'd0, '0, W'(12'h3ff));
    check("ovf_err",  W'(bus.err), 1);
    check("ovf_len",  W'(bus.arr_len), 16);
    check("ovf_s0",   slot(0), W'(12'h0f0));
    check("ovf_s15",  slot(15), W'(12'h10c));
    @(posedge clk); #1;
    check("ovf_err_1cyc", W'(bus.err), 0);

    // len=5, DELETE idx 1.
    do_reset();
    add_n(5, W'(12'h010));
    send(2'd2, 6'd1, '0);
    count_busy(n);
    check("del_busy_cycles", W'(n), 4);
    check("del_len", W'(bus.arr_len), 4);
    check("del_s0",  slot(0), W'(12'h010));
    check("del_s1",  slot(1), W'(12'h012));
    check("del_s2",  slot(2), W'(12'h013));
    check("del_s3",  slot(3), W'(12'h014));
    check("del_s4",  slot(4), 0);
    send(2'd2, 6'd7, '0);
    check("del_oob_err",  W'(bus.err), 1);
    check("del_oob_busy", W'(bus.busy), 0);
    check("del_oob_len",  W'(bus.arr_len), 4);

    // len=8, CLEAR, then ADD held through WIPE.
    do_reset();
    add_n(8, W'(12'h020));
    send(2'd3, '0, '0);
    check("clr_len", W'(bus.arr_len), 0);
    check("clr_s7",  slot(7), 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd0;
    bus.cmd_obj   = W'(12'habc);
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("clr_ready_low", W'(n), 16);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("clr_add_len", W'(bus.arr_len), 1);
    check("clr_add_s0",  slot(0), W'(12'habc));
    check("clr_add_s1",  slot(1), 0);

    // Reset during the 2nd SHIFT cycle.
    do_reset();
    add_n(5, W'(12'h030));
    send(2'd2, 6'd0, '0);
    @(posedge clk); #1;
    check("rst_mid_busy", W'(bus.busy), 1);
    rst = 1'b1;
    #2;
    check("rst_mid_arr", W'(|bus.obj_arr_packed), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_ready", W'(bus.cmd_ready), 1);
    check("rst_mid_len",   W'(bus.arr_len), 0);
    send(2'd0, '0, W'(12'h777));
    check("rst_mid_add_s0", slot(0), W'(12'h777));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
